// File: rtl/pc_unit.sv
// Program-counter unit for the fetch stage: PC register, sequential and
// PC-relative target generation, absolute jump/call/return through a circular
// return-address stack, and trap redirect with faulting-PC capture.
module pc_unit #(
   parameter int unsigned             WIDTH     = 16,
   parameter logic [WIDTH-1:0]        RESET_VEC = '0,
   parameter logic [WIDTH-1:0]        TRAP_VEC  = WIDTH'('h100),
   parameter int unsigned             RAS_DEPTH = 4,
   localparam int unsigned            PTR_W     = $clog2(RAS_DEPTH),
   localparam int unsigned            CNT_W     = $clog2(RAS_DEPTH + 1)
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             i_stall,
   input  logic             i_br_taken,
   input  logic [WIDTH-1:0] i_br_offset,
   input  logic             i_jmp,
   input  logic             i_call,
   input  logic             i_ret,
   input  logic [WIDTH-1:0] i_tgt,
   input  logic             i_trap,
   output logic [WIDTH-1:0] o_pc,
   output logic [WIDTH-1:0] o_pc_inc,
   output logic [WIDTH-1:0] o_epc,
   output logic [CNT_W-1:0] o_ras_count,
   output logic             o_ras_underflow
);

   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] r_epc;
   logic [PTR_W-1:0] r_ptr;    // index of the current top entry
   logic [CNT_W-1:0] r_cnt;
   logic             r_uflow;
   logic [WIDTH-1:0] r_ras [RAS_DEPTH];

   logic [WIDTH-1:0] w_pc_inc;
   logic [WIDTH-1:0] w_pc_nxt;
   logic [WIDTH-1:0] w_epc_nxt;
   logic [PTR_W-1:0] w_ptr_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_uflow_nxt;
   logic             w_push;
   logic             w_ras_empty;
   logic             w_ras_full;

   assign w_pc_inc    = r_pc + WIDTH'(1);
   assign w_ras_empty = (r_cnt == '0);
   assign w_ras_full  = (r_cnt == CNT_W'(RAS_DEPTH));

   // Next-state selection by strict request priority; stall freezes everything.
   always_comb begin
      w_pc_nxt    = r_pc;
      w_epc_nxt   = r_epc;
      w_ptr_nxt   = r_ptr;
      w_cnt_nxt   = r_cnt;
      w_uflow_nxt = 1'b0;
      w_push      = 1'b0;
      if (!i_stall) begin
         if (i_trap) begin
            w_pc_nxt  = TRAP_VEC;
            w_epc_nxt = r_pc;
         end else if (i_ret && !w_ras_empty) begin
            w_pc_nxt  = r_ras[r_ptr];
            w_ptr_nxt = r_ptr - PTR_W'(1);
            w_cnt_nxt = r_cnt - CNT_W'(1);
         end else if (i_ret) begin
            // Return with nothing to return to: fall through sequentially.
            w_pc_nxt    = w_pc_inc;
            w_uflow_nxt = 1'b1;
         end else if (i_call) begin
            w_pc_nxt  = i_tgt;
            w_push    = 1'b1;
            w_ptr_nxt = r_ptr + PTR_W'(1);
            if (!w_ras_full) begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end else if (i_jmp) begin
            w_pc_nxt = i_tgt;
         end else if (i_br_taken) begin
            w_pc_nxt = r_pc + i_br_offset;
         end else begin
            w_pc_nxt = w_pc_inc;
         end
      end
   end

   // Control state with asynchronous reset.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         r_pc    <= RESET_VEC;
         r_epc   <= '0;
         r_ptr   <= '0;
         r_cnt   <= '0;
         r_uflow <= 1'b0;
      end else begin
         r_pc    <= w_pc_nxt;
         r_epc   <= w_epc_nxt;
         r_ptr   <= w_ptr_nxt;
         r_cnt   <= w_cnt_nxt;
         r_uflow <= w_uflow_nxt;
      end
   end

   // RAS storage; contents need no reset since r_cnt gates every read.
   always_ff @(posedge CLK) begin
      if (w_push) begin
         r_ras[w_ptr_nxt] <= w_pc_inc;
      end
   end

   assign o_pc            = r_pc;
   assign o_pc_inc        = w_pc_inc;
   assign o_epc           = r_epc;
   assign o_ras_count     = r_cnt;
   assign o_ras_underflow = r_uflow;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: stimulus pushes hand-computed expected state,
// a monitor pops and compares shortly after each rising edge.
module tb_pc_unit;

   localparam int unsigned W = 16;

   typedef struct packed {
      logic [W-1:0] pc;
      logic [W-1:0] epc;
      logic [2:0]   cnt;
      logic         uf;
   } exp_t;

   logic          CLK = 1'b0;
   logic          reset = 1'b1;
   logic          stall = 1'b0, br_taken = 1'b0, jmp = 1'b0, call = 1'b0;
   logic          ret = 1'b0, trap = 1'b0;
   logic [W-1:0]  br_offset = '0, tgt = '0;
   logic [W-1:0]  pc, pc_inc, epc;
   logic [2:0]    ras_count;
   logic          ras_underflow;

   int total = 0;
   int bad   = 0;

   exp_t  exp_q [$];
   string name_q [$];

   pc_unit #(
      .WIDTH    (W),
      .RESET_VEC(16'h0000),
      .TRAP_VEC (16'h0100),
      .RAS_DEPTH(4)
   ) dut (
      .CLK            (CLK),
      .reset          (reset),
      .i_stall        (stall),
      .i_br_taken     (br_taken),
      .i_br_offset    (br_offset),
      .i_jmp          (jmp),
      .i_call         (call),
      .i_ret          (ret),
      .i_tgt          (tgt),
      .i_trap         (trap),
      .o_pc           (pc),
      .o_pc_inc       (pc_inc),
      .o_epc          (epc),
      .o_ras_count    (ras_count),
      .o_ras_underflow(ras_underflow)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string nm, input exp_t e);
      logic [W-1:0] e_inc;
      e_inc = e.pc + 16'd1;
      total++;
      if (pc !== e.pc || pc_inc !== e_inc || epc !== e.epc ||
          ras_count !== e.cnt || ras_underflow !== e.uf) begin
         bad++;
         $display("FAIL %s: got pc=%h inc=%h epc=%h cnt=%0d uf=%b want pc=%h inc=%h epc=%h cnt=%0d uf=%b",
                  nm, pc, pc_inc, epc, ras_count, ras_underflow,
                  e.pc, e_inc, e.epc, e.cnt, e.uf);
      end
   endtask

   // Monitor: the DUT presents new state after every edge.
   always @(posedge CLK) begin
      #1;
      if (exp_q.size() > 0) begin
         check(name_q.pop_front(), exp_q.pop_front());
      end
   end

   // One clock: inputs already applied at a falling edge; expectation queued.
   task automatic cyc(input string nm, input logic [W-1:0] e_pc, input logic [W-1:0] e_epc,
                      input logic [2:0] e_cnt, input logic e_uf);
      exp_t e;
      e.pc = e_pc; e.epc = e_epc; e.cnt = e_cnt; e.uf = e_uf;
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(posedge CLK);
      @(negedge CLK);
      {stall, br_taken, jmp, call, ret, trap} = '0;
      br_offset = '0;
      tgt = '0;
   endtask

   task automatic do_jmp(input logic [W-1:0] t, input logic [W-1:0] e_epc, input logic [2:0] e_cnt);
      jmp = 1'b1; tgt = t;
      cyc("jmp", t, e_epc, e_cnt, 1'b0);
   endtask

   initial begin
      exp_t r;
      #1;
      r = '0;
      check("reset_state", r);
      @(negedge CLK);
      reset = 1'b0;

      cyc("idle1", 16'h0001, 16'h0000, 3'd0, 1'b0);
      cyc("idle2", 16'h0002, 16'h0000, 3'd0, 1'b0);
      cyc("idle3", 16'h0003, 16'h0000, 3'd0, 1'b0);

      // Branch arithmetic
      do_jmp(16'h0010, 16'h0000, 3'd0);
      br_taken = 1'b1; br_offset = 16'hFFF8;
      cyc("br_neg", 16'h0008, 16'h0000, 3'd0, 1'b0);
      do_jmp(16'hFFFE, 16'h0000, 3'd0);
      br_taken = 1'b1; br_offset = 16'h0004;
      cyc("br_wrap", 16'h0002, 16'h0000, 3'd0, 1'b0);
      do_jmp(16'hFFFF, 16'h0000, 3'd0);
      cyc("inc_wrap", 16'h0000, 16'h0000, 3'd0, 1'b0);

      // Call/return nesting
      do_jmp(16'h0005, 16'h0000, 3'd0);
      call = 1'b1; tgt = 16'h0200;
      cyc("call1", 16'h0200, 16'h0000, 3'd1, 1'b0);
      call = 1'b1; tgt = 16'h0300;
      cyc("call2", 16'h0300, 16'h0000, 3'd2, 1'b0);
      ret = 1'b1;
      cyc("ret2", 16'h0201, 16'h0000, 3'd1, 1'b0);
      ret = 1'b1;
      cyc("ret1", 16'h0006, 16'h0000, 3'd0, 1'b0);
      ret = 1'b1;
      cyc("ret_empty", 16'h0007, 16'h0000, 3'd0, 1'b1);
      cyc("uf_clear", 16'h0008, 16'h0000, 3'd0, 1'b0);

      // RAS overflow: five pushes into four entries
      do_jmp(16'h0010, 16'h0000, 3'd0);
      call = 1'b1; tgt = 16'h0020; cyc("ovf_call1", 16'h0020, 16'h0000, 3'd1, 1'b0);
      call = 1'b1; tgt = 16'h0030; cyc("ovf_call2", 16'h0030, 16'h0000, 3'd2, 1'b0);
      call = 1'b1; tgt = 16'h0040; cyc("ovf_call3", 16'h0040, 16'h0000, 3'd3, 1'b0);
      call = 1'b1; tgt = 16'h0050; cyc("ovf_call4", 16'h0050, 16'h0000, 3'd4, 1'b0);
      call = 1'b1; tgt = 16'h0060; cyc("ovf_call5", 16'h0060, 16'h0000, 3'd4, 1'b0);
      ret = 1'b1; cyc("ovf_ret1", 16'h0051, 16'h0000, 3'd3, 1'b0);
      ret = 1'b1; cyc("ovf_ret2", 16'h0041, 16'h0000, 3'd2, 1'b0);
      ret = 1'b1; cyc("ovf_ret3", 16'h0031, 16'h0000, 3'd1, 1'b0);
      ret = 1'b1; cyc("ovf_ret4", 16'h0021, 16'h0000, 3'd0, 1'b0);
      ret = 1'b1; cyc("ovf_ret5", 16'h0022, 16'h0000, 3'd0, 1'b1);
      cyc("ovf_uf_clr", 16'h0023, 16'h0000, 3'd0, 1'b0);

      // Priority: trap beats everything and leaves the RAS alone
      do_jmp(16'h0030, 16'h0000, 3'd0);
      call = 1'b1; tgt = 16'h0041; cyc("pri_setup", 16'h0041, 16'h0000, 3'd1, 1'b0);
      cyc("pri_idle", 16'h0042, 16'h0000, 3'd1, 1'b0);
      trap = 1'b1; ret = 1'b1; call = 1'b1; jmp = 1'b1; br_taken = 1'b1;
      tgt = 16'h0555; br_offset = 16'h0010;
      cyc("trap_pri", 16'h0100, 16'h0042, 3'd1, 1'b0);
      ret = 1'b1; call = 1'b1; tgt = 16'h0666;
      cyc("ret_over_call", 16'h0031, 16'h0042, 3'd0, 1'b0);

      // Stall holds state and suppresses the underflow pulse
      for (int i = 0; i < 3; i++) begin
         stall = 1'b1; jmp = 1'b1; tgt = 16'h0777;
         cyc("stall_jmp", 16'h0031, 16'h0042, 3'd0, 1'b0);
      end
      stall = 1'b1; ret = 1'b1;
      cyc("stall_ret", 16'h0031, 16'h0042, 3'd0, 1'b0);
      jmp = 1'b1; tgt = 16'h0777;
      cyc("jmp_after_stall", 16'h0777, 16'h0042, 3'd0, 1'b0);

      // Asynchronous reset between edges
      do_jmp(16'h0010, 16'h0042, 3'd0);
      call = 1'b1; tgt = 16'h0020; cyc("rst_call1", 16'h0020, 16'h0042, 3'd1, 1'b0);
      call = 1'b1; tgt = 16'h0030; cyc("rst_call2", 16'h0030, 16'h0042, 3'd2, 1'b0);
      call = 1'b1; tgt = 16'h0123; cyc("rst_call3", 16'h0123, 16'h0042, 3'd3, 1'b0);
      #2 reset = 1'b1;
      #1;
      r = '0;
      check("async_reset", r);
      @(negedge CLK);
      reset = 1'b0;
      ret = 1'b1;
      cyc("ret_after_rst", 16'h0001, 16'h0000, 3'd0, 1'b1);

      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
